bp_pht_arbiter: RTL

Controller that owns the single-port pattern history table (PHT) of 2-bit counters used by the pshare predictor. It sequences the post-reset table initialisation, then shares the single PHT port between prediction lookups and resolved-branch updates, buffering updates in a small FIFO. It also keeps lookup and misprediction statistics for the predictor evaluation benches.

---
 rtl/bp_pht_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/bp_pht_arbiter.sv
// PHT port owner for the pshare predictor: sweeps the table to weakly-not-taken after reset,
// then shares the single port between 1-cycle lookups and FIFO-buffered counter updates.
module bp_pht_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int IDX_W      = 7,
    parameter int QDEPTH     = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lk_valid,
    output logic              lk_ready,
    input  logic [ADDR_W-1:0] lk_pc,
    output logic              pred_valid,
    output logic              pred_taken,
    output logic [1:0]        pred_ctr,
    input  logic              upd_valid,
    output logic              upd_ready,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [1:0]        upd_ctr,
    output logic              pht_en,
    output logic              pht_we,
    output logic [IDX_W-1:0]  pht_addr,
    output logic [1:0]        pht_wdata,
    input  logic [1:0]        pht_rdata,
    output logic              init_done,
    output logic [31:0]       lookup_count,
    output logic [31:0]       mispredict_count
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(QDEPTH);
    localparam logic [STV_W-1:0] STARVE_LIM = STV_W'(STARVE_MAX);
    localparam logic [IDX_W-1:0] LAST_IDX   = '1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [1:0]       ctr;
        logic             taken;
    } upd_entry_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] init_idx_q;
    upd_entry_t       fifo_mem [QDEPTH];
    upd_entry_t       head;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [STV_W-1:0] starve_q;
    logic             rd_pending_q;
    logic [1:0]       pred_ctr_q;
    logic [31:0]      lookup_q, misp_q;

    logic fifo_empty, fifo_full, in_run, force_drain;
    logic lk_grant, upd_push, drain;
    logic unused_pc_bits;

    function automatic logic [1:0] sat_ctr(input logic [1:0] c, input logic t);
        if (t) return (c == 2'b11) ? 2'b11 : c + 2'b01;
        else   return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    assign fifo_empty  = (count_q == '0);
    assign fifo_full   = (count_q == FULL_COUNT);
    assign in_run      = reset && (state_q == ST_RUN);
    assign force_drain = !fifo_empty && (fifo_full || starve_q == STARVE_LIM);

    // Handshakes depend only on registered state so requesters never see a combinational loop.
    assign lk_ready  = in_run && !force_drain;
    assign upd_ready = reset && !fifo_full;
    assign lk_grant  = lk_valid && lk_ready;
    assign upd_push  = upd_valid && upd_ready;
    assign drain     = in_run && !fifo_empty && (force_drain || !lk_valid);
    assign head      = fifo_mem[rd_ptr_q];

    assign pred_valid       = reset && rd_pending_q;
    assign pred_ctr         = pred_valid ? pht_rdata : pred_ctr_q;
    assign pred_taken       = pred_ctr[1];
    assign init_done        = reset && (state_q == ST_RUN);
    assign lookup_count     = lookup_q;
    assign mispredict_count = misp_q;

    assign unused_pc_bits = ^{lk_pc[ADDR_W-1:IDX_W+2], lk_pc[1:0],
                              upd_pc[ADDR_W-1:IDX_W+2], upd_pc[1:0]};

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        pht_en    = 1'b0;
        pht_we    = 1'b0;
        pht_addr  = '0;
        pht_wdata = 2'b00;
        case (state_q)
            ST_INIT: begin
                pht_en    = reset;
                pht_we    = reset;
                pht_addr  = init_idx_q;
                pht_wdata = 2'b01;
                if (init_idx_q == LAST_IDX) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (drain) begin
                    pht_en    = 1'b1;
                    pht_we    = 1'b1;
                    pht_addr  = head.idx;
                    pht_wdata = sat_ctr(head.ctr, head.taken);
                end else if (lk_grant) begin
                    pht_en   = 1'b1;
                    pht_addr = lk_pc[IDX_W+1:2];
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_INIT;
            init_idx_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            starve_q     <= '0;
            rd_pending_q <= 1'b0;
            pred_ctr_q   <= 2'b00;
            lookup_q     <= '0;
            misp_q       <= '0;
        end else begin
            state_q      <= state_d;
            rd_pending_q <= lk_grant;
            if (state_q == ST_INIT) init_idx_q <= init_idx_q + IDX_W'(1);
            if (rd_pending_q) pred_ctr_q <= pht_rdata;

            if (upd_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (drain)    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({upd_push, drain})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase

            if (drain || fifo_empty)
                starve_q <= '0;
            else if (lk_grant && starve_q != STARVE_LIM)
                starve_q <= starve_q + STV_W'(1);

            if (lk_grant) lookup_q <= lookup_q + 32'd1;
            if (upd_push && (upd_ctr[1] != upd_taken)) misp_q <= misp_q + 32'd1;
        end
    end

    // NOTE: FIFO storage has no reset; the count and pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (upd_push)
            fifo_mem[wr_ptr_q] <= '{idx: upd_pc[IDX_W+1:2], ctr: upd_ctr, taken: upd_taken};
    end

endmodule
